// File: rtl/uart_mem_tx_if.sv
// uart_mem_tx_if: start/count, RAM port-B and TX-pin signals of uart_mem_tx
// master: the transmitter (drives ren/raddr/tx/busy/done/led)
// slave:  its environment (drives start/byte_cnt/rdata)
interface uart_mem_tx_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              i_start;
  logic [ADDR_W-1:0] i_byte_cnt;
  logic              o_mem_ren;
  logic [ADDR_W-1:0] o_mem_raddr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_uart_tx;
  logic              o_busy;
  logic              o_done;
  logic              o_led;
  modport master (
    input  i_start, i_byte_cnt, i_mem_rdata,
    output o_mem_ren, o_mem_raddr, o_uart_tx, o_busy, o_done, o_led
  );
  modport slave (
    output i_start, i_byte_cnt, i_mem_rdata,
    input  o_mem_ren, o_mem_raddr, o_uart_tx, o_busy, o_done, o_led
  );
endinterface

// File: rtl/uart_mem_tx.sv
// uart_mem_tx: drains i_byte_cnt bytes from RAM port B (from address 0) onto an 8N1 UART line
// Ports: i_clk fabric clock, i_reset async active-low reset, bus (uart_mem_tx_if.master):
//   i_start/i_byte_cnt launch, o_mem_ren/o_mem_raddr/i_mem_rdata RAM read, o_uart_tx line,
//   o_busy frame in progress, o_done completion pulse, o_led toggles per o_done.
// Optional: define UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_mem_tx #(
  parameter int CLK_FREQ = 125000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_mem_tx_if.master bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW = CPB > 1 ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BMAX = BW'(CPB - 1);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_LAT = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5, DONE = 3'd6;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd7;
  logic par;
`endif
  logic [2:0] state;
  logic [ADDR_W-1:0] cnt, idx, raddr;
  logic [BW-1:0] bcnt;
  logic [2:0] bit_n;
  logic [DATA_W-1:0] sh;
  logic ren, tx, busy, done, led;
  logic bit_end;
  assign bit_end = bcnt == BMAX;
  assign bus.o_mem_ren = ren;
  assign bus.o_mem_raddr = raddr;
  assign bus.o_uart_tx = tx;
  assign bus.o_busy = busy;
  assign bus.o_done = done;
  assign bus.o_led = led;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      raddr <= '0;
      bcnt <= '0;
      bit_n <= '0;
      sh <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
      ren <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      led <= 1'b0;
    end else begin
      ren <= 1'b0;
      done <= 1'b0;
      bcnt <= bit_end ? '0 : bcnt + BW'(1);
      case (state)
        IDLE: if (bus.i_start) begin
          cnt <= bus.i_byte_cnt;
          idx <= '0;
          if (bus.i_byte_cnt == '0) begin
            state <= DONE;
            done <= 1'b1;
            led <= ~led;
          end else begin
            state <= RD_REQ;
            busy <= 1'b1;
            ren <= 1'b1;
            raddr <= '0;
          end
        end
        RD_REQ: state <= RD_LAT;
        RD_LAT: begin
          sh <= bus.i_mem_rdata;
`ifdef UART_TX_PARITY_EN
          par <= ^bus.i_mem_rdata;
`endif
          bcnt <= '0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          tx <= sh[0];
          sh <= sh >> 1;
          bit_n <= '0;
          state <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_n == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx <= par;
            state <= PARITY;
`else
            tx <= 1'b1;
            state <= STOP;
`endif
          end else begin
            tx <= sh[0];
            sh <= sh >> 1;
            bit_n <= bit_n + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          tx <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          if (idx + ADDR_W'(1) == cnt) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            led <= ~led;
          end else begin
            idx <= idx + ADDR_W'(1);
            raddr <= idx + ADDR_W'(1);
            ren <= 1'b1;
            state <= RD_REQ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
